chan_accum_bank: RTL and testbench

Parametrised multi-channel signed accumulator bank that generalises the single gated `Z <= X + Y + ...` accumulator in the top-level datapath. It accepts operand pairs over a valid/ready stream tagged with a channel index and keeps one running sum per channel. On request it drains every channel in order over a second valid/ready stream, clearing each channel as its value is accepted. It sits between the extracted compute block and downstream consumers.

---
 rtl/chan_accum_bank.sv | 140 ++++++++++++++
 tb/tb_chan_accum_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/chan_accum_bank.sv
// Multi-channel signed accumulator bank with in-order drain over a valid/ready stream.
// Define ACC_SAT_EN for saturating accumulation; the default build wraps.
module chan_accum_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned NCH    = 4,
  parameter int unsigned CH_W   = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              drain_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              drain_done,
  output logic              bad_ch
);

  localparam int unsigned SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_n;
  logic [CH_W-1:0]    idx_q, idx_n;
  logic [ACC_W-1:0]   acc_q [NCH];
  logic [ACC_W-1:0]   acc_n [NCH];
  logic [NCH-1:0]     ovf_q, ovf_n;
  logic               in_ready_n, out_valid_n, out_ovf_n, drain_done_n, bad_ch_n;
  logic [ACC_W-1:0]   out_data_n;
  logic signed [SUM_W-1:0] sum;
  logic               sum_ovf;
  logic [ACC_W-1:0]   sum_f;
  logic               beat_ok, ch_ok;

  assign out_ch = idx_q;

  // Next-state, accumulate/clear and registered-output preparation.
  always_comb begin
    state_n      = state_q;
    idx_n        = idx_q;
    ovf_n        = ovf_q;
    for (int i = 0; i < int'(NCH); i++) acc_n[i] = acc_q[i];
    in_ready_n   = 1'b0;
    out_valid_n  = 1'b0;
    out_data_n   = '0;
    out_ovf_n    = 1'b0;
    drain_done_n = 1'b0;
    bad_ch_n     = 1'b0;

    beat_ok = in_valid && in_ready;
    ch_ok   = 32'(in_ch) < 32'(NCH);
    sum     = SUM_W'($signed(acc_q[in_ch])) + SUM_W'($signed(in_a)) + SUM_W'($signed(in_b));
    sum_ovf = (sum > ACC_MAX) || (sum < ACC_MIN);
`ifdef ACC_SAT_EN
    if (sum > ACC_MAX)      sum_f = ACC_MAX[ACC_W-1:0];
    else if (sum < ACC_MIN) sum_f = ACC_MIN[ACC_W-1:0];
    else                    sum_f = sum[ACC_W-1:0];
`else
    sum_f = sum[ACC_W-1:0];
`endif

    if (beat_ok) begin
      if (ch_ok) begin
        acc_n[in_ch] = sum_f;
        if (sum_ovf) ovf_n[in_ch] = 1'b1;
      end else begin
        bad_ch_n = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (drain_req) begin
          state_n = S_DRAIN;
          idx_n   = '0;
        end
      end
      S_DRAIN: begin
        if (out_valid && out_ready) begin
          acc_n[idx_q] = '0;
          ovf_n[idx_q] = 1'b0;
          if (idx_q == LAST_CH) begin
            state_n      = S_DONE;
            idx_n        = '0;
            drain_done_n = 1'b1;
          end else begin
            idx_n = idx_q + CH_W'(1);
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    in_ready_n = (state_n == S_IDLE);
    // Drain outputs reflect the channel after this cycle's accumulate/clear.
    if (state_n == S_DRAIN) begin
      out_valid_n = 1'b1;
      out_data_n  = acc_n[idx_n];
      out_ovf_n   = ovf_n[idx_n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ovf_q      <= '0;
      for (int i = 0; i < int'(NCH); i++) acc_q[i] <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      drain_done <= 1'b0;
      bad_ch     <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      ovf_q      <= ovf_n;
      for (int i = 0; i < int'(NCH); i++) acc_q[i] <= acc_n[i];
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      out_ovf    <= out_ovf_n;
      drain_done <= drain_done_n;
      bad_ch     <= bad_ch_n;
    end
  end

endmodule

// File: tb/tb_chan_accum_bank.sv
// Directed bench for chan_accum_bank: table of accumulate/drain vectors plus corner sequences.
module tb_chan_accum_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, drain_req, out_valid, out_ready, out_ovf, drain_done, bad_ch;
  logic [1:0]  in_ch, out_ch;
  logic [7:0]  in_a, in_b;
  logic [11:0] out_data;

  logic        b_in_valid, b_in_ready, b_drain_req, b_out_valid, b_out_ready;
  logic        b_out_ovf, b_drain_done, b_bad_ch;
  logic [1:0]  b_in_ch, b_out_ch;
  logic [7:0]  b_in_a, b_in_b;
  logic [11:0] b_out_data;

  chan_accum_bank #(.DATA_W(8), .ACC_W(12), .NCH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_a(in_a), .in_b(in_b), .drain_req(drain_req), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data), .out_ovf(out_ovf),
    .drain_done(drain_done), .bad_ch(bad_ch)
  );

  chan_accum_bank #(.DATA_W(8), .ACC_W(12), .NCH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ch(b_in_ch),
    .in_a(b_in_a), .in_b(b_in_b), .drain_req(b_drain_req), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_ch(b_out_ch), .out_data(b_out_data), .out_ovf(b_out_ovf),
    .drain_done(b_drain_done), .bad_ch(b_bad_ch)
  );

`ifdef ACC_SAT_EN
  localparam logic [11:0] E_POS = 12'h7FF;
  localparam logic [11:0] E_NEG = 12'h800;
`else
  localparam logic [11:0] E_POS = 12'h8EE;  // 2286 wrapped = -1810
  localparam logic [11:0] E_NEG = 12'h700;  // -2304 wrapped = 1792
`endif

  typedef struct packed {
    logic [1:0]       ch;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [7:0]       n;
    logic [3:0][11:0] d;
    logic [3:0]       o;
  } vec_t;

  vec_t vecs [6];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] n);
    in_ch = ch; in_a = a; in_b = b;
    if (n != 8'd0) begin
      in_valid = 1'b1;
      repeat (n) tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic start_drain();
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
  endtask

  // Walks a drain already started; rpat gives out_ready per cycle.
  task automatic drain_seq(input string nm, input logic [3:0][11:0] ed, input logic [3:0] eo,
                           input logic [15:0] rpat, output int cyc);
    int idx;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 16) begin
      out_ready = rpat[cyc];
      chk({nm, ".valid"},    32'(out_valid), 32'd1);
      chk({nm, ".ch"},       32'(out_ch),    32'(idx));
      chk({nm, ".data"},     32'(out_data),  32'(ed[idx]));
      chk({nm, ".ovf"},      32'(out_ovf),   32'(eo[idx]));
      chk({nm, ".in_ready"}, 32'(in_ready),  32'd0);
      tick();
      cyc++;
      if (out_ready) idx++;
    end
    out_ready = 1'b1;
    chk({nm, ".done"},       32'(drain_done), 32'd1);
    chk({nm, ".done_valid"}, 32'(out_valid),  32'd0);
    chk({nm, ".done_rdy"},   32'(in_ready),   32'd0);
    tick();
    chk({nm, ".idle_rdy"},   32'(in_ready),   32'd1);
    chk({nm, ".idle_done"},  32'(drain_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [11:0] b_exp [3];

    vecs[0] = '{2'd0, 8'd0,   8'd0,   8'd0, {12'h0, 12'h0, 12'h0, 12'h0},   4'b0000};
    vecs[1] = '{2'd1, 8'd5,   8'hFD,  8'd3, {12'h0, 12'h0, 12'h006, 12'h0}, 4'b0000};
    vecs[2] = '{2'd0, 8'd0,   8'd0,   8'd0, {12'h0, 12'h0, 12'h0, 12'h0},   4'b0000};
    vecs[3] = '{2'd2, 8'd127, 8'd127, 8'd9, {12'h0, E_POS, 12'h0, 12'h0},   4'b0100};
    vecs[4] = '{2'd0, 8'h80,  8'h80,  8'd8, {12'h0, 12'h0, 12'h0, 12'h800}, 4'b0000};
    vecs[5] = '{2'd3, 8'h80,  8'h80,  8'd9, {E_NEG, 12'h0, 12'h0, 12'h0},   4'b1000};

    rst = 1'b1;
    in_valid = 1'b0; in_ch = '0; in_a = '0; in_b = '0; drain_req = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_ch = '0; b_in_a = '0; b_in_b = '0; b_drain_req = 1'b0;
    b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst.in_ready",   32'(in_ready),   32'd1);
    chk("rst.out_valid",  32'(out_valid),  32'd0);
    chk("rst.out_ch",     32'(out_ch),     32'd0);
    chk("rst.out_data",   32'(out_data),   32'd0);
    chk("rst.out_ovf",    32'(out_ovf),    32'd0);
    chk("rst.drain_done", 32'(drain_done), 32'd0);
    chk("rst.bad_ch",     32'(bad_ch),     32'd0);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].n);
      start_drain();
      drain_seq($sformatf("vec%0d", i), vecs[i].d, vecs[i].o, 16'hFFFF, cyc);
      chk($sformatf("vec%0d.cycles", i), 32'(cyc), 32'd4);
    end

    // Backpressure: three stalled cycles on the ch1 beat.
    send(2'd1, 8'd1, 8'd2, 8'd1);
    start_drain();
    drain_seq("bp", {12'h0, 12'h0, 12'h003, 12'h0}, 4'b0000, 16'b1111_1111_1111_0001, cyc);
    chk("bp.cycles", 32'(cyc), 32'd7);

    // Beat and drain_req together, then a beat offered while draining.
    in_valid = 1'b1; in_ch = 2'd3; in_a = 8'd1; in_b = 8'd1; drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    in_ch = 2'd0; in_a = 8'd50; in_b = 8'd50;
    drain_seq("simul", {12'h002, 12'h0, 12'h0, 12'h0}, 4'b0000, 16'hFFFF, cyc);
    in_valid = 1'b0;
    start_drain();
    drain_seq("post_simul", {12'h0, 12'h0, 12'h0, 12'h0}, 4'b0000, 16'hFFFF, cyc);

    // Out-of-range channel on the three-channel bank.
    b_in_valid = 1'b1; b_in_ch = 2'd0; b_in_a = 8'd10; b_in_b = 8'd0;
    tick();
    chk("bad.first", 32'(b_bad_ch), 32'd0);
    b_in_ch = 2'd3; b_in_a = 8'd5; b_in_b = 8'd5;
    tick();
    b_in_valid = 1'b0;
    chk("bad.pulse", 32'(b_bad_ch),   32'd1);
    chk("bad.ready", 32'(b_in_ready), 32'd1);
    tick();
    chk("bad.clear", 32'(b_bad_ch), 32'd0);
    b_exp[0] = 12'd10; b_exp[1] = 12'd0; b_exp[2] = 12'd0;
    b_drain_req = 1'b1;
    tick();
    b_drain_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bad.drain%0d.valid", c), 32'(b_out_valid), 32'd1);
      chk($sformatf("bad.drain%0d.ch", c),    32'(b_out_ch),    32'(c));
      chk($sformatf("bad.drain%0d.data", c),  32'(b_out_data),  32'(b_exp[c]));
      chk($sformatf("bad.drain%0d.ovf", c),   32'(b_out_ovf),   32'd0);
      tick();
    end
    chk("bad.done", 32'(b_drain_done), 32'd1);
    tick();

    // Asynchronous reset while on the ch1 beat.
    send(2'd1, 8'd7, 8'd0, 8'd1);
    start_drain();
    out_ready = 1'b1;
    tick();
    chk("rstmid.ch",   32'(out_ch),   32'd1);
    chk("rstmid.data", 32'(out_data), 32'd7);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.valid",    32'(out_valid), 32'd0);
    chk("rstmid.in_ready", 32'(in_ready),  32'd1);
    chk("rstmid.out_data", 32'(out_data),  32'd0);
    chk("rstmid.out_ch",   32'(out_ch),    32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    start_drain();
    drain_seq("post_rst", {12'h0, 12'h0, 12'h0, 12'h0}, 4'b0000, 16'hFFFF, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
